ps2_frame_receiver: RTL and testbench

//  PS/2 keyboard line receiver; feeds ps2Decode directly (ps2Code -> ps2InCode).

---
 rtl/ps2_frame_receiver_if.sv | 26 ++
 rtl/ps2_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_frame_receiver_if.sv
// Pin and event bundle between a PS/2 line and ps2_frame_receiver.
// master drives the PS/2 pins; slave is the receiver that produces key events.
interface ps2_frame_receiver_if;
  // ps2Valid and ps2Err are single-cycle strobes with no ready and no back-pressure.
  // A consumer must take each event in the cycle it appears. ps2Break and ps2Ext are
  // qualified by ps2Valid and hold their value until the next event. ps2Code is level
  // data: it always shows the make code currently held.
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] ps2Code;
  logic       ps2Valid;
  logic       ps2Break;
  logic       ps2Ext;
  logic       ps2Err;
  logic [1:0] fsm_state;

  modport master (
    output ps2Clk, ps2Data,
    input  ps2Code, ps2Valid, ps2Break, ps2Ext, ps2Err, fsm_state
  );

  modport slave (
    input  ps2Clk, ps2Data,
    output ps2Code, ps2Valid, ps2Break, ps2Ext, ps2Err, fsm_state
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard line receiver: sync/filter, 11-bit frame deserialise, F0/E0 prefix tracking.
// Optional PS2_PARITY_CHECK_EN: when defined, odd-parity failures discard the frame.
module ps2_frame_receiver #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 10000
) (
  input logic clk,
  input logic reset,
  ps2_frame_receiver_if.slave bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic           clk_s1, clk_s2, data_s1, data_s2;
  logic           clk_filt;
  logic [FCW-1:0] filt_cnt;
  logic           fall;
  logic           fall_data;

  state_t         state;
  logic [3:0]     bit_cnt;
  logic [7:0]     shift;
  logic [TCW-1:0] tmo_cnt;
  logic           break_pend, ext_pend;
  logic           parity_ok;

  logic [7:0]     code_q;
  logic           valid_q, break_q, ext_q, err_q;

  assign bus.ps2Code   = code_q;
  assign bus.ps2Valid  = valid_q;
  assign bus.ps2Break  = break_q;
  assign bus.ps2Ext    = ext_q;
  assign bus.ps2Err    = err_q;
  assign bus.fsm_state = state;

  // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples;
  // fall and the data captured with it form one registered bit event.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      fall      <= 1'b0;
      fall_data <= 1'b1;
    end else begin
      clk_s1  <= bus.ps2Clk;
      clk_s2  <= clk_s1;
      data_s1 <= bus.ps2Data;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      if (clk_s2 != clk_filt) begin
        if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
          clk_filt  <= clk_s2;
          filt_cnt  <= '0;
          fall      <= ~clk_s2;
          fall_data <= data_s2;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  always_comb begin
    parity_ok = (^shift) ^ parity_bit;
  end
`else
  always_comb begin
    parity_ok = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tmo_cnt    <= '0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      code_q     <= 8'h00;
      valid_q    <= 1'b0;
      break_q    <= 1'b0;
      ext_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        bit_cnt <= '0;
        // A start bit of 1 is line noise, not a frame; it is ignored silently.
        if (fall && !fall_data) begin
          state   <= DATA;
          bit_cnt <= 4'd1;
        end
      end else if (fall) begin
        tmo_cnt <= '0;
        bit_cnt <= bit_cnt + 4'd1;
        if (state == DATA) begin
          shift <= {fall_data, shift[7:1]};
          if (bit_cnt == 4'd8) state <= PARITY;
        end else if (state == PARITY) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_bit <= fall_data;
`endif
          state <= STOP;
        end else begin
          state   <= IDLE;
          bit_cnt <= '0;
          if (fall_data && parity_ok) begin
            if (shift == 8'hF0) begin
              break_pend <= 1'b1;
            end else if (shift == 8'hE0) begin
              ext_pend <= 1'b1;
            end else begin
              valid_q    <= 1'b1;
              break_q    <= break_pend;
              ext_q      <= ext_pend;
              break_pend <= 1'b0;
              ext_pend   <= 1'b0;
              if (!break_pend) code_q <= shift;
              else if (shift == code_q) code_q <= 8'h00;
            end
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (tmo_cnt == TCW'(TIMEOUT_CYC - 1)) begin
        // A stalled frame leaves any pending prefix meaningless, so drop both.
        state      <= IDLE;
        bit_cnt    <= '0;
        tmo_cnt    <= '0;
        err_q      <= 1'b1;
        break_pend <= 1'b0;
        ext_pend   <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: PS/2 frame driver, event scoreboard, summary.
module tb_ps2_frame_receiver;

  localparam int TIMEOUT_CYC = 10000;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [10:0] exp_q[$];
  logic [7:0]  e_code;
  logic        e_brk, e_ext;

  ps2_frame_receiver_if bus ();

  ps2_frame_receiver #(.FILTER_LEN(4), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard expectations: word = {err, break, ext, code} as seen on the event cycle
  task automatic expect_valid(input logic brk, input logic ext, input logic [7:0] code);
    e_brk  = brk;
    e_ext  = ext;
    e_code = code;
    exp_q.push_back({1'b0, brk, ext, code});
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, e_brk, e_ext, e_code});
  endtask

  always @(negedge clk) begin
    logic [10:0] w;
    if (!rst && (bus.ps2Valid || bus.ps2Err)) begin
      check("valid_err_exclusive", 32'(bus.ps2Valid & bus.ps2Err), 32'd0);
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("event", {21'd0, bus.ps2Err, bus.ps2Break, bus.ps2Ext, bus.ps2Code}, {21'd0, w});
      end
    end
  end

  // drivers
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b, input int hp);
    bus.ps2Data = b;
    wait_cycles(hp);
    bus.ps2Clk = 1'b0;
    wait_cycles(hp);
    bus.ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    int hp;
    hp = $urandom_range(40, 60);
    send_bit(1'b0, hp);
    for (int i = 0; i < 8; i++) send_bit(b[i], hp);
    send_bit((~^b) ^ bad_parity, hp);
    send_bit(1'b1, hp);
    bus.ps2Data = 1'b1;
    wait_cycles($urandom_range(100, 300));
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    int hp;
    hp = $urandom_range(40, 60);
    send_bit(1'b0, hp);
    for (int i = 0; i < nbits - 1; i++) send_bit(b[i], hp);
    bus.ps2Data = 1'b1;
  endtask

  task automatic drain(input string tag);
    wait_cycles(30);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_code"},  32'(bus.ps2Code), 32'h00);
    check({tag, "_flags"}, {28'd0, bus.ps2Valid, bus.ps2Break, bus.ps2Ext, bus.ps2Err}, 32'd0);
    check({tag, "_state"}, 32'(bus.fsm_state), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    e_code = 8'h00;
    e_brk  = 1'b0;
    e_ext  = 1'b0;
    bus.ps2Clk  = 1'b1;
    bus.ps2Data = 1'b1;
    rst = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    check_reset_state("reset");

    // single make
    expect_valid(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    drain("make_1c");

    // typematic repeat, then release
    expect_valid(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    drain("f0_no_strobe");
    expect_valid(1'b1, 1'b0, 8'h00);
    send_frame(8'h1C, 1'b0);
    drain("break_1c");

    // extended make and release
    send_frame(8'hE0, 1'b0);
    expect_valid(1'b0, 1'b1, 8'h75);
    send_frame(8'h75, 1'b0);
    drain("ext_make_75");
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    expect_valid(1'b1, 1'b1, 8'h00);
    send_frame(8'h75, 1'b0);
    drain("ext_break_75");

    // bad parity
`ifdef PS2_PARITY_CHECK_EN
    expect_err();
`else
    expect_valid(1'b0, 1'b0, 8'h16);
`endif
    send_frame(8'h16, 1'b1);
    drain("bad_parity_16");

    // pending break lost to a mid-frame timeout
    send_frame(8'hF0, 1'b0);
    expect_err();
    send_partial(8'h55, 4);
    wait_cycles(TIMEOUT_CYC + 100);
    drain("timeout_err");
    @(negedge clk);
    check("timeout_state_idle", 32'(bus.fsm_state), 32'd0);
    expect_valid(1'b0, 1'b0, 8'h1E);
    send_frame(8'h1E, 1'b0);
    drain("make_1e_after_timeout");

    // reset in the middle of a frame
    send_partial(8'hA5, 6);
    wait_cycles(20);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    e_code = 8'h00;
    e_brk  = 1'b0;
    e_ext  = 1'b0;
    check_reset_state("midframe_reset");
    expect_valid(1'b0, 1'b0, 8'h2D);
    send_frame(8'h2D, 1'b0);
    drain("make_2d_after_reset");

    // 3-cycle clock glitch with data low must not start a frame
    bus.ps2Data = 1'b0;
    bus.ps2Clk  = 1'b0;
    wait_cycles(3);
    bus.ps2Clk  = 1'b1;
    wait_cycles(20);
    bus.ps2Data = 1'b1;
    @(negedge clk);
    check("glitch_state_idle", 32'(bus.fsm_state), 32'd0);
    expect_valid(1'b0, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b0);
    drain("make_3c_after_glitch");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
